codif_prio_enc: RTL

- Registered N-to-log2(N) priority encoder. It is the encoding counterpart of the team's 2-4 enable-gated decoders.
- Request lines are latched into a sticky pending mask. The highest-index pending line is encoded to binary and presented on a VALID/READY output.
- Each captured request is emitted exactly once.
- Sits between the decoded one-hot/multi-hot event lines and any consumer that needs a binary index, such as a decoder or a register-file select.

---
 rtl/codif_pkg.sv | 24 ++
 rtl/prio_enc_comb.sv | 25 ++
 rtl/codif_prio_enc.sv | 99 +++++++++
 3 files changed

// File: rtl/codif_pkg.sv
// Shared definitions for the codif encoder family: output-stage state encodings
// and the width helper used by the elaboration-time parameter checks.
package codif_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-index priority encoder; any is set when vec has a bit set.
module prio_enc_comb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // NOTE: defaults come first so every path assigns idx/any and no latch is inferred;
    // blocking assignments are correct here because this block is purely combinational.
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last match, i.e. the highest index, wins.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codif_prio_enc.sv
// Registered priority encoder: sticky pending mask feeding a one-deep VALID/READY
// output register, highest pending index first, every captured request emitted once.
module codif_prio_enc
    import codif_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic [N-1:0] REQ,
    output logic [W-1:0] Y,
    output logic         VALID,
    input  logic         READY,
    output logic         BUSY,
    output logic         OVF
);

    if (!is_pow2(N)) begin : g_bad_n
        $error("codif_prio_enc: N must be a power of 2 and at least 2");
    end
    if (W != clog2(N)) begin : g_bad_w
        $error("codif_prio_enc: W must equal clog2(N)");
    end

    logic [N-1:0] p_q, p_d;
    logic [W-1:0] y_q, y_d;
    logic         state_q, state_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] sel;
    logic         any;
    logic         load;
    logic [N-1:0] p_clr;
    logic [N-1:0] req_cap;

    prio_enc_comb #(.N(N), .W(W)) u_enc (
        .vec (p_q),
        .idx (sel),
        .any (any)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        load    = 1'b0;
        p_clr   = '0;

        case (state_q)
            ST_EMPTY: begin
                if (any) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (READY) begin
                    if (any) load    = 1'b1;
                    else     state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load) begin
            y_d        = sel;
            p_clr[sel] = 1'b1;
        end

        // A re-assertion in the same cycle its old copy is loaded sets the bit again
        // and is not a merge, because the old copy has already left the mask.
        req_cap = EN ? REQ : '0;
        p_d     = (p_q & ~p_clr) | req_cap;
        ovf_d   = |(req_cap & p_q & ~p_clr);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q     <= '0;
            y_q     <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            y_q     <= y_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Y     = y_q;
    assign VALID = (state_q == ST_FULL);
    assign OVF   = ovf_q;
    assign BUSY  = (|p_q) | VALID;

endmodule
